// File: rtl/asymdata_inbuf_if.sv
// Narrow-producer-to-FIFO push bus for the asymmetric input buffer.
// The producer (master) drives subword requests and the FIFO full flag; the buffer (slave) returns the word strobe and status.
interface asymdata_inbuf_if #(
  parameter int in_width  = 8,
  parameter int out_width = 16
);
  // Handshake: a subword is taken on every rising edge where push_req_n=0, with no backpressure.
  // A completing push or flush with fifo_full=0 yields push_wd_n=0 for exactly one cycle, with data_out valid
  // in that cycle. With fifo_full=1 the request is dropped, the state is kept, and push_error is raised.
  logic                 push_req_n;
  logic                 flush_n;
  logic [in_width-1:0]  data_in;
  logic                 fifo_full;
  logic                 push_wd_n;
  logic [out_width-1:0] data_out;
  logic                 inbuf_full;
  logic                 part_wd;
  logic                 push_error;

  modport master (
    output push_req_n, flush_n, data_in, fifo_full,
    input  push_wd_n, data_out, inbuf_full, part_wd, push_error
  );

  modport slave (
    input  push_req_n, flush_n, data_in, fifo_full,
    output push_wd_n, data_out, inbuf_full, part_wd, push_error
  );
endinterface

// File: rtl/asymdata_inbuf.sv
// Push-side asymmetric input buffer: packs K narrow subwords into one FIFO word.
// It can also flush a partially filled word.
module asymdata_inbuf #(
  parameter int in_width    = 8,
  parameter int out_width   = 16,
  parameter int err_mode    = 0,
  parameter int byte_order  = 0,
  parameter int flush_value = 0
) (
  input  logic clk_push,
  input  logic rst_push,
  input  logic init_push_n,
  asymdata_inbuf_if.slave bus
);
  localparam int K  = out_width / in_width;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]        LAST     = CW'(K - 1);
  localparam logic [in_width-1:0]  FILL_SUB = (flush_value != 0) ? {in_width{1'b1}} : '0;
  localparam logic [out_width-1:0] FILL_WD  = (flush_value != 0) ? {out_width{1'b1}} : '0;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [out_width-1:0] acc_q, acc_d;
  logic                 push_wd_n_q, push_wd_n_d;
  logic [out_width-1:0] data_out_q, data_out_d;
  logic                 push_error_q, push_error_d;

  function automatic int slot_lsb(input int i);
    return (byte_order == 0) ? (out_width - (i + 1) * in_width) : (i * in_width);
  endfunction

  function automatic logic [out_width-1:0] put_slot(input logic [out_width-1:0] w,
                                                    input logic [CW-1:0] s,
                                                    input logic [in_width-1:0] d);
    logic [out_width-1:0] r;
    r = w;
    for (int i = 0; i < K; i++)
      if (CW'(i) == s) r[slot_lsb(i) +: in_width] = d;
    return r;
  endfunction

  // Slots s..K-1 have not been written yet, so they take the fill value.
  function automatic logic [out_width-1:0] fill_from(input logic [out_width-1:0] w,
                                                     input logic [CW-1:0] s);
    logic [out_width-1:0] r;
    r = w;
    for (int i = 0; i < K; i++)
      if (CW'(i) >= s) r[slot_lsb(i) +: in_width] = FILL_SUB;
    return r;
  endfunction

  logic push, flush;
  assign push  = ~bus.push_req_n;
  assign flush = ~bus.flush_n;

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    push_wd_n_d  = 1'b1;
    data_out_d   = data_out_q;
    push_error_d = (err_mode != 0) ? 1'b0 : push_error_q;
    if (flush && cnt_q != '0) begin
      if (bus.fifo_full) begin
        push_error_d = 1'b1;
      end else begin
        data_out_d  = fill_from(acc_q, cnt_q);
        push_wd_n_d = 1'b0;
        // A subword arriving together with the flush starts the next word.
        if (push) begin
          acc_d = put_slot(FILL_WD, '0, bus.data_in);
          cnt_d = CW'(1);
        end else begin
          acc_d = FILL_WD;
          cnt_d = '0;
        end
      end
    end else if (push) begin
      if (cnt_q == LAST) begin
        if (bus.fifo_full) begin
          push_error_d = 1'b1;
        end else begin
          data_out_d  = put_slot(acc_q, cnt_q, bus.data_in);
          push_wd_n_d = 1'b0;
          acc_d       = FILL_WD;
          cnt_d       = '0;
        end
      end else begin
        acc_d = put_slot(acc_q, cnt_q, bus.data_in);
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_push) begin
    if (rst_push || !init_push_n) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      push_wd_n_q  <= 1'b1;
      data_out_q   <= '0;
      push_error_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      push_wd_n_q  <= push_wd_n_d;
      data_out_q   <= data_out_d;
      push_error_q <= push_error_d;
    end
  end

  assign bus.push_wd_n  = push_wd_n_q;
  assign bus.data_out   = data_out_q;
  assign bus.push_error = push_error_q;
  assign bus.inbuf_full = (cnt_q == LAST);
  assign bus.part_wd    = (cnt_q != '0);
endmodule
